// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  function automatic logic takes_byte(input state_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHECK};
  endfunction
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: shifts stream bytes into a little-endian 32-bit word.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0] cnt;
  assign word_full = shift && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift) begin
      word <= {din, word[31:8]};
      cnt  <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that parses a length/payload/checksum byte stream into imem writes
// and holds the core in reset until a load completes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS = 64,
  parameter int IDX_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);
  state_t state, next;
  logic [IDX_W-1:0] idx;
  logic [15:0] len, n_len;
  logic [7:0] len_lo, csum;
  logic [31:0] word, data_q;
  logic [63:0] addr_q;
  logic take, go, word_full;
  assign take  = byte_valid & byte_ready;
  assign go    = start & (state inside {IDLE, DONE, ERR});
  assign n_len = {byte_data, len_lo};
  byte_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (go),
    .shift    (take && state == DATA),
    .din      (byte_data),
    .word     (word),
    .word_full(word_full)
  );
  // Write strobe is a pure state decode; address/data hold their last write otherwise.
  assign imem_we    = state == WRITE;
  assign imem_addr  = imem_we ? {{(62-IDX_W){1'b0}}, idx, 2'b00} : addr_q;
  assign imem_wdata = imem_we ? word : data_q;
  always_comb begin
    next = state;
    case (state)
      LEN_LO:  next = take ? LEN_HI : state;
      LEN_HI:  next = !take ? state : n_len > 16'(WORDS) ? ERR : n_len == '0 ? CHECK : DATA;
      DATA:    next = word_full ? WRITE : state;
      WRITE:   next = 16'(idx) + 16'd1 == len ? CHECK : DATA;
      CHECK:   next = !take ? state : byte_data == csum ? DONE : ERR;
      default: next = state;
    endcase
    if (go) next = LEN_LO;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
      idx        <= '0;
      len        <= '0;
      len_lo     <= '0;
      csum       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= next;
      byte_ready <= takes_byte(next);
      if (go) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        core_rst_n <= 1'b0;
        idx        <= '0;
        csum       <= '0;
      end else begin
        busy       <= !(state inside {IDLE, DONE, ERR});
        done       <= state == DONE;
        error      <= state == ERR;
        core_rst_n <= state == DONE;
      end
      if (take && state == LEN_LO) len_lo <= byte_data;
      if (take && state == LEN_HI) len <= n_len;
      if (take && state == DATA) csum <= csum ^ byte_data;
      if (state == WRITE) begin
        idx    <= idx + 1'b1;
        addr_q <= imem_addr;
        data_q <= word;
      end
    end
  end
endmodule
